// File: rtl/axi_mport_bridge.sv
// axi_mport_bridge: N_RD SRAM-like read ports plus one write port onto an AXI3 master.
// Reads are round-robin arbitrated onto AR, one outstanding AR slot at a time.
// R beats are routed back by rid with no storage.
// Writes land in a circular buffer and issue AW/W concurrently.
// A buffer entry stays visible to the read hazard check until its B response.
module axi_mport_bridge #(
  parameter int N_RD       = 2,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int ID_W       = 4,
  parameter int WBUF_DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  // read ports
  input  logic [N_RD-1:0]          rd_req_i,
  input  logic [N_RD*ADDR_W-1:0]   rd_addr_i,
  input  logic [N_RD*8-1:0]        rd_len_i,
  output logic [N_RD-1:0]          rd_addr_ok_o,
  output logic [N_RD-1:0]          rd_data_ok_o,
  output logic [DATA_W-1:0]        rd_rdata_o,
  output logic                     rd_last_o,
  // write port
  input  logic                     wr_req_i,
  input  logic [ADDR_W-1:0]        wr_addr_i,
  input  logic [DATA_W-1:0]        wr_wdata_i,
  input  logic [DATA_W/8-1:0]      wr_wstrb_i,
  output logic                     wr_addr_ok_o,
  output logic                     wr_data_ok_o,
  // AR
  output logic [ID_W-1:0]          arid_o,
  output logic [ADDR_W-1:0]        araddr_o,
  output logic [7:0]               arlen_o,
  output logic [2:0]               arsize_o,
  output logic [1:0]               arburst_o,
  output logic [1:0]               arlock_o,
  output logic [3:0]               arcache_o,
  output logic [2:0]               arprot_o,
  output logic                     arvalid_o,
  input  logic                     arready_i,
  // R
  input  logic [ID_W-1:0]          rid_i,
  input  logic [DATA_W-1:0]        rdata_i,
  input  logic [1:0]               rresp_i,
  input  logic                     rlast_i,
  input  logic                     rvalid_i,
  output logic                     rready_o,
  // AW
  output logic [ID_W-1:0]          awid_o,
  output logic [ADDR_W-1:0]        awaddr_o,
  output logic [7:0]               awlen_o,
  output logic [2:0]               awsize_o,
  output logic [1:0]               awburst_o,
  output logic [1:0]               awlock_o,
  output logic [3:0]               awcache_o,
  output logic [2:0]               awprot_o,
  output logic                     awvalid_o,
  input  logic                     awready_i,
  // W
  output logic [ID_W-1:0]          wid_o,
  output logic [DATA_W-1:0]        wdata_o,
  output logic [DATA_W/8-1:0]      wstrb_o,
  output logic                     wlast_o,
  output logic                     wvalid_o,
  input  logic                     wready_i,
  // B
  input  logic [ID_W-1:0]          bid_i,
  input  logic [1:0]               bresp_i,
  input  logic                     bvalid_i,
  output logic                     bready_o
);

  localparam int OFF = $clog2(DATA_W/8);
  localparam int PW  = $clog2(WBUF_DEPTH);
  localparam int RRW = (N_RD > 1) ? $clog2(N_RD) : 1;
  localparam int SW  = DATA_W/8;
  localparam int TW  = ADDR_W - OFF;
  localparam logic [ID_W-1:0] WR_ID = ID_W'(N_RD);

  typedef enum logic {AR_IDLE, AR_SEND} ar_st_e;

  // ---------------- fixed AXI fields ----------------
  assign arsize_o  = 3'(OFF);
  assign awsize_o  = 3'(OFF);
  assign arburst_o = 2'b01;
  assign awburst_o = 2'b01;
  assign arlock_o  = 2'b00;
  assign awlock_o  = 2'b00;
  assign arcache_o = 4'b0000;
  assign awcache_o = 4'b0000;
  assign arprot_o  = 3'b000;
  assign awprot_o  = 3'b000;
  assign awlen_o   = 8'd0;
  assign wlast_o   = 1'b1;
  assign awid_o    = WR_ID;
  assign wid_o     = WR_ID;
  assign rready_o  = 1'b1;

  // ---------------- write buffer ----------------
  logic [ADDR_W-1:0] wb_addr_q [WBUF_DEPTH];
  logic [DATA_W-1:0] wb_data_q [WBUF_DEPTH];
  logic [SW-1:0]     wb_strb_q [WBUF_DEPTH];
  logic [PW:0]       alloc_q, iss_q, ret_q;
  logic              aw_done_q, w_done_q, wr_data_ok_q;
  logic [PW:0]       cnt;
  logic              wr_acc, iss_pend, aw_done_n, w_done_n, iss_adv, b_fire;
  logic [WBUF_DEPTH-1:0] wb_vld;

  assign cnt          = alloc_q - ret_q;
  assign wr_addr_ok_o = ~cnt[PW];           // cnt == WBUF_DEPTH is the only value with the top bit set
  assign wr_acc       = wr_req_i & wr_addr_ok_o;
  assign iss_pend     = (iss_q != alloc_q);
  assign awvalid_o    = iss_pend & ~aw_done_q;
  assign wvalid_o     = iss_pend & ~w_done_q;
  assign aw_done_n    = aw_done_q | (awvalid_o & awready_i);
  assign w_done_n     = w_done_q  | (wvalid_o  & wready_i);
  assign iss_adv      = iss_pend & aw_done_n & w_done_n;
  assign bready_o     = (ret_q != iss_q);
  assign b_fire       = bvalid_i & bready_o;
  assign awaddr_o     = wb_addr_q[iss_q[PW-1:0]];
  assign wdata_o      = wb_data_q[iss_q[PW-1:0]];
  assign wstrb_o      = wb_strb_q[iss_q[PW-1:0]];
  assign wr_data_ok_o = wr_data_ok_q;

  // Buffer payload storage, written at the alloc slot on acceptance
  always_ff @(posedge clk_i) begin
    if (wr_acc) begin
      wb_addr_q[alloc_q[PW-1:0]] <= wr_addr_i;
      wb_data_q[alloc_q[PW-1:0]] <= wr_wdata_i;
      wb_strb_q[alloc_q[PW-1:0]] <= wr_wstrb_i;
    end
  end

  // Pointer and handshake-flag bookkeeping for accept / issue / retire
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      alloc_q      <= '0;
      iss_q        <= '0;
      ret_q        <= '0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      wr_data_ok_q <= 1'b0;
    end else begin
      if (wr_acc) alloc_q <= alloc_q + 1'b1;
      if (iss_adv) begin
        iss_q     <= iss_q + 1'b1;
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
      end else begin
        aw_done_q <= aw_done_n;
        w_done_q  <= w_done_n;
      end
      if (b_fire) ret_q <= ret_q + 1'b1;
      wr_data_ok_q <= b_fire;
    end
  end

  // An entry is live from acceptance until its B handshake (retire..alloc window)
  for (genvar e = 0; e < WBUF_DEPTH; e++) begin : g_wb_vld
    logic [PW-1:0] rel;
    assign rel       = PW'(e) - ret_q[PW-1:0];
    assign wb_vld[e] = ({1'b0, rel} < cnt);
  end

  // ---------------- read hazard ----------------
  logic [N_RD-1:0] hazard, elig;

  // A port is blocked if its word address hits any live entry or the write accepted this cycle
  for (genvar p = 0; p < N_RD; p++) begin : g_hz
    logic [TW-1:0] rtag;
    logic          hz;
    assign rtag = rd_addr_i[p*ADDR_W+OFF +: TW];
    // Compare against every live buffer entry plus the incoming write
    always_comb begin
      hz = wr_acc && (wr_addr_i[ADDR_W-1:OFF] == rtag);
      for (int e = 0; e < WBUF_DEPTH; e++)
        if (wb_vld[e] && (wb_addr_q[e][ADDR_W-1:OFF] == rtag)) hz = 1'b1;
    end
    assign hazard[p] = hz;
  end

  assign elig = rd_req_i & ~hazard;

  // ---------------- AR arbitration ----------------
  ar_st_e            ar_st_q, ar_st_d;
  logic [RRW-1:0]    rr_q;
  logic              gnt_vld;
  logic [RRW-1:0]    gnt_idx;
  logic [ADDR_W-1:0] gnt_addr, ar_addr_q;
  logic [7:0]        gnt_len, ar_len_q;
  logic [ID_W-1:0]   ar_id_q;

  // Round-robin pick: first eligible port at or after rr_q, wrapping
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int j = 0; j < N_RD; j++)
      for (int p = 0; p < N_RD; p++)
        if (!gnt_vld && elig[p] &&
            ((int'(rr_q) + j == p) || (int'(rr_q) + j == p + N_RD))) begin
          gnt_vld = 1'b1;
          gnt_idx = RRW'(p);
        end
  end

  // Request fields of the granted port
  always_comb begin
    gnt_addr = '0;
    gnt_len  = '0;
    for (int p = 0; p < N_RD; p++)
      if (RRW'(p) == gnt_idx) begin
        gnt_addr = rd_addr_i[p*ADDR_W +: ADDR_W];
        gnt_len  = rd_len_i[p*8 +: 8];
      end
  end

  // AR state register
  always_ff @(posedge clk_i) begin
    if (reset_i) ar_st_q <= AR_IDLE;
    else         ar_st_q <= ar_st_d;
  end

  // AR next state: one request in flight on the channel at a time
  always_comb begin
    ar_st_d = ar_st_q;
    case (ar_st_q)
      AR_IDLE: if (gnt_vld)   ar_st_d = AR_SEND;
      AR_SEND: if (arready_i) ar_st_d = AR_IDLE;
      default:                ar_st_d = AR_IDLE;
    endcase
  end

  // AR outputs: accept only from IDLE, so no same-cycle accept on the arready edge
  always_comb begin
    arvalid_o    = (ar_st_q == AR_SEND);
    rd_addr_ok_o = '0;
    if (ar_st_q == AR_IDLE && gnt_vld) rd_addr_ok_o[gnt_idx] = 1'b1;
  end

  // Latch the granted request and rotate priority past the winner
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rr_q      <= '0;
      ar_addr_q <= '0;
      ar_len_q  <= '0;
      ar_id_q   <= '0;
    end else if (ar_st_q == AR_IDLE && gnt_vld) begin
      ar_addr_q <= gnt_addr;
      ar_len_q  <= gnt_len;
      ar_id_q   <= ID_W'(gnt_idx);
      rr_q      <= (gnt_idx == RRW'(N_RD-1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  assign araddr_o = ar_addr_q;
  assign arlen_o  = ar_len_q;
  assign arid_o   = ar_id_q;

  // ---------------- R routing ----------------
  for (genvar p = 0; p < N_RD; p++) begin : g_rd_ok
    assign rd_data_ok_o[p] = rvalid_i && (rid_i == ID_W'(p));
  end
  assign rd_rdata_o = rdata_i;
  assign rd_last_o  = rlast_i;

  // Beats tagged with the write id or beyond are not ours and are dropped
  rid_in_range: assert property (@(posedge clk_i) disable iff (reset_i)
                                 rvalid_i |-> (rid_i < WR_ID));

endmodule

// File: tb/tb_axi_mport_bridge.sv
// Randomised + directed bench for axi_mport_bridge against a queue-based reference model.
module tb_axi_mport_bridge;
  localparam int N_RD = 2, ADDR_W = 32, DATA_W = 32, ID_W = 4, WBD = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [N_RD-1:0]        rd_req, rd_addr_ok, rd_data_ok;
  logic [N_RD*ADDR_W-1:0] rd_addr;
  logic [N_RD*8-1:0]      rd_len;
  logic [DATA_W-1:0]      rd_rdata;
  logic                   rd_last;
  logic                   wr_req, wr_addr_ok, wr_data_ok;
  logic [ADDR_W-1:0]      wr_addr;
  logic [DATA_W-1:0]      wr_wdata;
  logic [3:0]             wr_wstrb;
  logic [ID_W-1:0]        arid, awid, wid, rid, bid;
  logic [ADDR_W-1:0]      araddr, awaddr;
  logic [7:0]             arlen, awlen;
  logic [2:0]             arsize, awsize, arprot, awprot;
  logic [1:0]             arburst, awburst, arlock, awlock, rresp, bresp;
  logic [3:0]             arcache, awcache, wstrb;
  logic                   arvalid, arready, rlast, rvalid, rready;
  logic                   awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [DATA_W-1:0]      rdata, wdata;

  axi_mport_bridge #(.N_RD(N_RD), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W),
                     .WBUF_DEPTH(WBD)) dut (
    .clk_i(clk), .reset_i(reset),
    .rd_req_i(rd_req), .rd_addr_i(rd_addr), .rd_len_i(rd_len),
    .rd_addr_ok_o(rd_addr_ok), .rd_data_ok_o(rd_data_ok), .rd_rdata_o(rd_rdata), .rd_last_o(rd_last),
    .wr_req_i(wr_req), .wr_addr_i(wr_addr), .wr_wdata_i(wr_wdata), .wr_wstrb_i(wr_wstrb),
    .wr_addr_ok_o(wr_addr_ok), .wr_data_ok_o(wr_data_ok),
    .arid_o(arid), .araddr_o(araddr), .arlen_o(arlen), .arsize_o(arsize), .arburst_o(arburst),
    .arlock_o(arlock), .arcache_o(arcache), .arprot_o(arprot), .arvalid_o(arvalid), .arready_i(arready),
    .rid_i(rid), .rdata_i(rdata), .rresp_i(rresp), .rlast_i(rlast), .rvalid_i(rvalid), .rready_o(rready),
    .awid_o(awid), .awaddr_o(awaddr), .awlen_o(awlen), .awsize_o(awsize), .awburst_o(awburst),
    .awlock_o(awlock), .awcache_o(awcache), .awprot_o(awprot), .awvalid_o(awvalid), .awready_i(awready),
    .wid_o(wid), .wdata_o(wdata), .wstrb_o(wstrb), .wlast_o(wlast), .wvalid_o(wvalid), .wready_i(wready),
    .bid_i(bid), .bresp_i(bresp), .bvalid_i(bvalid), .bready_o(bready)
  );

  // ---------------- reference model ----------------
  typedef struct {logic [31:0] a; logic [31:0] d; logic [3:0] s;} went_t;
  went_t       mq[$];          // accepted, not yet B-acked writes, oldest first
  int          n_iss;          // leading entries of mq already sent on AW+W
  bit          m_awd, m_wd;    // halves of the head-of-issue entry already handshaken
  bit          m_busy;         // an AR is being presented
  bit          m_wdok;         // completion pulse owed this cycle
  int          m_rr;
  logic [31:0] m_pa;
  logic [7:0]  m_pl;
  int          m_pid;
  int          e_gnt;
  bit          e_wacc;
  int          n_chk = 0, n_err = 0, dut_wdok = 0;
  logic [31:0] pool [4] = '{32'h80, 32'h100, 32'h200, 32'h300};

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h want %0h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [29:0] tag(logic [31:0] a);
    return a[31:2];
  endfunction

  task automatic model_reset();
    mq.delete(); n_iss = 0; m_awd = 0; m_wd = 0; m_busy = 0; m_wdok = 0; m_rr = 0;
  endtask

  task automatic idle();
    rd_req = '0; rd_addr = '0; rd_len = '0;
    wr_req = 0; wr_addr = '0; wr_wdata = '0; wr_wstrb = '0;
    arready = 0; awready = 0; wready = 0; bvalid = 0; bid = '0; bresp = '0;
    rvalid = 0; rid = '0; rdata = '0; rlast = 0; rresp = '0;
  endtask

  // Settle, derive what every output must be from the model, compare.
  task automatic eval();
    bit hz [N_RD];
    bit pend;
    logic [N_RD-1:0] e_rdok;
    #1;
    e_wacc = wr_req && (mq.size() < WBD);
    for (int p = 0; p < N_RD; p++) begin
      hz[p] = e_wacc && (tag(wr_addr) == tag(rd_addr[p*32 +: 32]));
      foreach (mq[i]) if (tag(mq[i].a) == tag(rd_addr[p*32 +: 32])) hz[p] = 1;
    end
    e_gnt = -1;
    if (!m_busy)
      for (int j = 0; j < N_RD; j++) begin
        int k;
        k = (m_rr + j) % N_RD;
        if (e_gnt < 0 && rd_req[k] && !hz[k]) e_gnt = k;
      end
    e_rdok = '0;
    if (e_gnt >= 0) e_rdok[e_gnt] = 1'b1;
    chk("rd_addr_ok", rd_addr_ok, e_rdok);
    chk("wr_addr_ok", wr_addr_ok, (mq.size() < WBD));
    chk("arvalid", arvalid, m_busy);
    if (m_busy) begin
      chk("araddr", araddr, m_pa);
      chk("arlen", arlen, m_pl);
      chk("arid", arid, m_pid);
    end
    pend = n_iss < mq.size();
    chk("awvalid", awvalid, pend && !m_awd);
    chk("wvalid", wvalid, pend && !m_wd);
    if (pend) begin
      chk("awaddr", awaddr, mq[n_iss].a);
      chk("wdata", wdata, mq[n_iss].d);
      chk("wstrb", wstrb, mq[n_iss].s);
    end
    chk("bready", bready, n_iss > 0);
    chk("wr_data_ok", wr_data_ok, m_wdok);
    chk("rd_data_ok", rd_data_ok, rvalid ? (2'b01 << rid) : 2'b00);
    if (rvalid) chk("rd_beat", {rd_last, rd_rdata}, {rlast, rdata});
    chk("consts", {arsize, awsize, arburst, awburst, awlen, wlast, rready, awid, wid,
                   arlock, awlock, arcache, awcache, arprot, awprot},
                  {3'd2, 3'd2, 2'b01, 2'b01, 8'd0, 1'b1, 1'b1, 4'd2, 4'd2,
                   2'b0, 2'b0, 4'b0, 4'b0, 3'b0, 3'b0});
    if (wr_data_ok === 1'b1) dut_wdok++;
  endtask

  // Advance the model across the coming clock edge, then move to the next negedge.
  task automatic adv();
    bit pend, bf;
    pend = n_iss < mq.size();
    bf = bvalid && n_iss > 0;
    if (m_busy) begin
      if (arready) m_busy = 0;
    end else if (e_gnt >= 0) begin
      m_busy = 1; m_pa = rd_addr[e_gnt*32 +: 32]; m_pl = rd_len[e_gnt*8 +: 8];
      m_pid = e_gnt; m_rr = (e_gnt + 1) % N_RD;
    end
    if (pend && awready) m_awd = 1;
    if (pend && wready)  m_wd = 1;
    if (pend && m_awd && m_wd) begin n_iss++; m_awd = 0; m_wd = 0; end
    if (bf) begin void'(mq.pop_front()); n_iss--; end
    if (e_wacc) mq.push_back('{wr_addr, wr_wdata, wr_wstrb});
    m_wdok = bf;
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle(); reset = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 0; model_reset();
  endtask

  initial begin
    idle(); reset = 1;
    @(negedge clk);
    do_reset();

    // reset state
    eval();
    chk("rst_state", {arvalid, awvalid, wvalid, bready, wr_data_ok, wr_addr_ok, rd_addr_ok}, 8'b00000100);
    adv();

    // both ports request: port0 first, then port1
    rd_req = 2'b11; rd_addr = {32'h200, 32'h100};
    eval(); chk("t1_gnt0", rd_addr_ok, 2'b01); adv();
    eval(); chk("t1_ar0", {arvalid, araddr, arid}, {1'b1, 32'h100, 4'd0}); adv();
    arready = 1;
    eval(); chk("t1_zero_lat", rd_addr_ok, 2'b00); adv();
    arready = 0;
    eval(); chk("t1_gnt1", rd_addr_ok, 2'b10); adv();
    eval(); chk("t1_ar1", {arvalid, araddr, arid}, {1'b1, 32'h200, 4'd1});
    arready = 1; rd_req = 2'b00; adv();

    // 4-beat burst on port0
    rd_req = 2'b01; rd_addr[31:0] = 32'h400; rd_len[7:0] = 8'd3;
    eval(); adv();
    rd_req = 2'b00;
    eval(); chk("t3_arlen", arlen, 8'd3); adv();
    for (int b = 0; b < 4; b++) begin
      rvalid = 1; rid = 4'd0; rdata = 32'hA000 + b; rlast = (b == 3);
      eval(); chk("t3_beat", {rd_data_ok, rd_last}, {2'b01, (b == 3)}); adv();
    end
    rvalid = 0; rlast = 0;

    // RAW hazard: write 0x80 and read 0x80 on port1 in the same cycle
    awready = 1; wready = 1; arready = 1;
    wr_req = 1; wr_addr = 32'h80; wr_wdata = 32'hDEAD_BEEF; wr_wstrb = 4'hF;
    rd_req = 2'b10; rd_addr = {32'h80, 32'h300};
    eval(); chk("t4_same_cyc", {wr_addr_ok, rd_addr_ok}, 3'b100); adv();
    wr_req = 0;
    for (int i = 0; i < 10; i++) begin
      rd_req = (i >= 2 && i < 5) ? 2'b11 : 2'b10;
      eval(); chk("t4_blk", rd_addr_ok[1], 1'b0);
      if (i == 2) chk("t4_p0", rd_addr_ok, 2'b01);
      adv();
    end
    bvalid = 1;
    eval(); chk("t4_bcyc", rd_addr_ok[1], 1'b0); adv();
    bvalid = 0;
    eval(); chk("t4_after", {rd_addr_ok, wr_data_ok}, 3'b101); adv();
    rd_req = 2'b00;
    eval(); adv();

    // fill the buffer with B stalled
    dut_wdok = 0; wr_req = 1; wr_wstrb = 4'hF;
    for (int i = 0; i < 4; i++) begin
      wr_addr = 32'h1000 + 4*i; wr_wdata = $urandom;
      eval(); chk("t5_acc", wr_addr_ok, 1'b1); adv();
    end
    wr_addr = 32'h1010;
    for (int i = 0; i < 2; i++) begin
      eval(); chk("t5_full", wr_addr_ok, 1'b0); adv();
    end
    bvalid = 1;
    eval(); chk("t5_bcyc_full", wr_addr_ok, 1'b0); adv();
    bvalid = 0;
    eval(); chk("t5_acc5", wr_addr_ok, 1'b1); adv();
    wr_req = 0;
    for (int i = 0; i < 40; i++) begin
      bvalid = (n_iss > 0);
      eval(); adv();
    end
    chk("t5_wdok_cnt", dut_wdok, 5);
    bvalid = 0;

    // AW accepted immediately, W stalled 3 cycles
    awready = 1; wready = 0;
    wr_req = 1; wr_addr = 32'h2000; wr_wdata = 32'h1234_5678;
    eval(); adv();
    wr_req = 0;
    eval(); chk("t6_both", {awvalid, wvalid}, 2'b11); adv();
    for (int i = 0; i < 3; i++) begin
      eval(); chk("t6_wonly", {awvalid, wvalid, bready}, 3'b010); adv();
    end
    wready = 1;
    eval(); chk("t6_wfire", {wvalid, bready}, 2'b10); adv();
    wready = 0;
    eval(); chk("t6_issued", {wvalid, bready}, 2'b01); adv();
    bvalid = 1;
    eval(); adv();
    bvalid = 0;

    // randomised traffic, with one reset in the middle
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) begin
        do_reset();
        eval();
        chk("rst_mid", {arvalid, awvalid, wvalid, bready, wr_data_ok}, 5'b0);
        adv();
      end
      rd_req = N_RD'($urandom_range(0, 3));
      for (int p = 0; p < N_RD; p++) begin
        rd_addr[p*32 +: 32] = pool[$urandom_range(0, 3)] | 32'($urandom_range(0, 3));
        rd_len[p*8 +: 8] = 8'($urandom_range(0, 15));
      end
      wr_req   = ($urandom_range(0, 2) == 0);
      wr_addr  = pool[$urandom_range(0, 3)] | 32'($urandom_range(0, 3));
      wr_wdata = $urandom;
      wr_wstrb = 4'($urandom_range(0, 15));
      arready  = 1'($urandom_range(0, 1));
      awready  = 1'($urandom_range(0, 1));
      wready   = 1'($urandom_range(0, 1));
      bvalid   = (n_iss > 0) && ($urandom_range(0, 1) == 1);
      rvalid   = 1'($urandom_range(0, 1));
      rid      = ID_W'($urandom_range(0, N_RD-1));
      rdata    = $urandom;
      rlast    = 1'($urandom_range(0, 1));
      eval(); adv();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
